alu_cmd_sequencer: RTL and testbench

Command sequencer between the UART receiver/transmitter and the ALU datapath. It assembles 3-byte command frames (opcode, operand A, operand B) from RX, issues one ALU operation, captures the 2*DATA_WIDTH result and the flags, and returns them to TX as three bytes over a valid/ready handshake. It owns the ALU exclusively and handles invalid opcodes, inter-byte timeouts and TX backpressure.

---
 rtl/alu_cmd_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer between the UART byte stream and the ALU: gathers opcode/A/B frames,
// fires one ALU operation and returns result low, result high and flags as three TX bytes.
//
// state      | meaning
// S_IDLE     | waiting for an opcode byte
// S_GET_A    | opcode latched, waiting for operand A
// S_GET_B    | operand A latched, waiting for operand B
// S_EXEC     | alu_en pulse cycle
// S_WAIT_RES | waiting for alu_valid, no timeout
// S_SEND_LO  | presenting result low byte
// S_SEND_HI  | presenting result high byte
// S_SEND_FLG | presenting zero-extended flags
// S_SEND_ERR | presenting ERR_CODE after a bad opcode
module alu_cmd_sequencer #(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    TIMEOUT_CYCLES = 1_000_000,
   parameter logic [DATA_WIDTH-1:0] ERR_CODE       = 8'hEE
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     rx_data,
   input  logic                      rx_valid,
   output logic [DATA_WIDTH-1:0]     alu_a,
   output logic [DATA_WIDTH-1:0]     alu_b,
   output logic [3:0]                alu_op,
   output logic                      alu_en,
   input  logic [2*DATA_WIDTH-1:0]   alu_result,
   input  logic [3:0]                alu_flags,
   input  logic                      alu_valid,
   output logic [DATA_WIDTH-1:0]     tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic                      busy,
   output logic                      err_opcode,
   output logic                      err_timeout,
   output logic                      rx_drop
);

   typedef enum logic [3:0] {
      S_IDLE, S_GET_A, S_GET_B, S_EXEC, S_WAIT_RES,
      S_SEND_LO, S_SEND_HI, S_SEND_FLG, S_SEND_ERR
   } state_t;

   // Down-counter reloaded on every accepted byte; terminal count 0 means the gap is used up.
   localparam logic [23:0] TMR_LOAD = 24'(TIMEOUT_CYCLES - 1);

   state_t                  state;
   logic [23:0]             tmr;
   logic [DATA_WIDTH-1:0]   res_hi;
   logic [3:0]              flg_reg;
   logic                    op_ok;
   logic                    tx_fire;
   logic                    in_tail;

   assign op_ok   = (rx_data[DATA_WIDTH-1:4] == '0) && (rx_data[3:0] <= 4'd13);
   assign tx_fire = tx_valid && tx_ready;
   assign in_tail = (state == S_EXEC) || (state == S_WAIT_RES) || (state == S_SEND_LO) ||
                    (state == S_SEND_HI) || (state == S_SEND_FLG) || (state == S_SEND_ERR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         tmr         <= '0;
         res_hi      <= '0;
         flg_reg     <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
         alu_en      <= 1'b0;
         tx_data     <= '0;
         tx_valid    <= 1'b0;
         busy        <= 1'b0;
         err_opcode  <= 1'b0;
         err_timeout <= 1'b0;
         rx_drop     <= 1'b0;
      end else begin
         alu_en      <= 1'b0;
         err_opcode  <= 1'b0;
         err_timeout <= 1'b0;
         rx_drop     <= rx_valid && in_tail;
         case (state)
            S_IDLE: begin
               if (rx_valid) begin
                  busy <= 1'b1;
                  tmr  <= TMR_LOAD;
                  if (op_ok) begin
                     alu_op <= rx_data[3:0];
                     state  <= S_GET_A;
                  end else begin
                     err_opcode <= 1'b1;
                     tx_data    <= ERR_CODE;
                     tx_valid   <= 1'b1;
                     state      <= S_SEND_ERR;
                  end
               end
            end
            S_GET_A, S_GET_B: begin
               // An arriving byte beats a simultaneous timeout.
               if (rx_valid) begin
                  tmr <= TMR_LOAD;
                  if (state == S_GET_A) begin
                     alu_a <= rx_data;
                     state <= S_GET_B;
                  end else begin
                     alu_b  <= rx_data;
                     alu_en <= 1'b1;
                     state  <= S_EXEC;
                  end
               end else if (tmr == '0) begin
                  err_timeout <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  tmr <= tmr - 24'd1;
               end
            end
            S_EXEC: state <= S_WAIT_RES;
            S_WAIT_RES: begin
               if (alu_valid) begin
                  res_hi   <= alu_result[2*DATA_WIDTH-1:DATA_WIDTH];
                  flg_reg  <= alu_flags;
                  tx_data  <= alu_result[DATA_WIDTH-1:0];
                  tx_valid <= 1'b1;
                  state    <= S_SEND_LO;
               end
            end
            S_SEND_LO: begin
               if (tx_fire) begin
                  tx_data <= res_hi;
                  state   <= S_SEND_HI;
               end
            end
            S_SEND_HI: begin
               if (tx_fire) begin
                  tx_data <= {{(DATA_WIDTH-4){1'b0}}, flg_reg};
                  state   <= S_SEND_FLG;
               end
            end
            S_SEND_FLG, S_SEND_ERR: begin
               if (tx_fire) begin
                  tx_valid <= 1'b0;
                  busy     <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            default: begin
               tx_valid <= 1'b0;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: bench-side ALU with one-cycle latency, negedge monitor,
// one task per scenario with hand-computed expected bytes and cycle offsets.
module tb_alu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  alu_a, alu_b;
   logic [3:0]  alu_op;
   logic        alu_en;
   logic [15:0] alu_result = '0;
   logic [3:0]  alu_flags = '0;
   logic        alu_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        busy, err_opcode, err_timeout, rx_drop;

   alu_cmd_sequencer #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .ERR_CODE(8'hEE)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
      .alu_result(alu_result), .alu_flags(alu_flags), .alu_valid(alu_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .err_opcode(err_opcode), .err_timeout(err_timeout), .rx_drop(rx_drop)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   int rx_cyc = 0;

   int en_cnt = 0, eo_cnt = 0, to_cnt = 0, drop_cnt = 0;
   int en_cyc = 0, eo_cyc = 0, to_cyc = 0;
   logic [7:0] en_a = '0, en_b = '0;
   logic [3:0] en_op = '0;
   logic [7:0] tx_q[$];
   int         txc_q[$];

   always @(negedge clk) begin
      if (alu_en) begin
         en_cnt++; en_cyc = cyc; en_a = alu_a; en_b = alu_b; en_op = alu_op;
      end
      if (err_opcode) begin eo_cnt++; eo_cyc = cyc; end
      if (err_timeout) begin to_cnt++; to_cyc = cyc; end
      if (rx_drop) drop_cnt++;
      if (tx_valid && tx_ready) begin tx_q.push_back(tx_data); txc_q.push_back(cyc); end
   end

   function automatic logic [19:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] r;
      logic cf, of, zf;
      r = '0; cf = 1'b0; of = 1'b0;
      case (op)
         4'd0: begin r = {7'b0, {1'b0, a} + {1'b0, b}}; cf = r[8]; end
         4'd1: r = {8'h00, a - b};
         4'd2: begin r = 16'(a) * 16'(b); of = (r[15:8] != 8'h00); end
         4'd3: if (b == 8'h00) begin r = 16'hFFFF; cf = 1'b1; end else r = {8'h00, a / b};
         4'd5: r = {8'h00, a | b};
         default: r = '0;
      endcase
      zf = (r == 16'h0000);
      return {r, cf, of, zf, 1'b0};
   endfunction

   // ALU stand-in: answers one cycle after alu_en.
   initial begin
      logic [19:0] m;
      forever begin
         @(negedge clk);
         if (alu_en && !rst) begin
            m = alu_model(alu_op, alu_a, alu_b);
            @(negedge clk);
            alu_result = m[19:4]; alu_flags = m[3:0]; alu_valid = 1'b1;
            @(negedge clk);
            alu_valid = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   // Callers are positioned at a negedge; the byte is sampled on the next posedge.
   task automatic send_byte(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1; rx_cyc = cyc;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic wait_tx(input int target, input string tag);
      int k;
      k = 0;
      while (tx_q.size() < target && k < 200) begin @(negedge clk); k++; end
      if (tx_q.size() < target) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_tx_wait: got %0d bytes, want %0d", tag, tx_q.size(), target);
      end
   endtask

   function automatic logic [7:0] txb(input int i);
      return (i < tx_q.size()) ? tx_q[i] : 8'hxx;
   endfunction

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      n_cmp++;
      if ({alu_a, alu_b, alu_op, alu_en, tx_data, tx_valid, busy, err_opcode, err_timeout, rx_drop} !== 34'h0) begin
         n_bad++; $display("FAIL reset_outputs: got %h, want 0",
            {alu_a, alu_b, alu_op, alu_en, tx_data, tx_valid, busy, err_opcode, err_timeout, rx_drop});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy, tx_valid, alu_en} !== 3'b000) begin
         n_bad++; $display("FAIL reset_release_idle: got busy/tx_valid/alu_en %b, want 000", {busy, tx_valid, alu_en});
      end
   endtask

   task automatic test_arith();
      logic [7:0] fr [3][3];
      logic [7:0] ex [3][3];
      int base, e0, c;
      fr = '{'{8'h00, 8'h05, 8'h03}, '{8'h02, 8'h10, 8'h10}, '{8'h03, 8'h07, 8'h00}};
      ex = '{'{8'h08, 8'h00, 8'h00}, '{8'h00, 8'h01, 8'h04}, '{8'hFF, 8'hFF, 8'h08}};
      for (int f = 0; f < 3; f++) begin
         base = tx_q.size(); e0 = en_cnt;
         for (int j = 0; j < 3; j++) send_byte(fr[f][j]);
         c = rx_cyc;
         wait_tx(base + 3, "arith");
         wait_cyc(c + 6);
         n_cmp++;
         if (en_cnt - e0 != 1 || en_cyc != c + 1) begin
            n_bad++; $display("FAIL arith%0d_alu_en: got %0d pulses at +%0d, want 1 at +1", f, en_cnt - e0, en_cyc - c);
         end
         n_cmp++;
         if ({en_op, en_a, en_b} !== {fr[f][0][3:0], fr[f][1], fr[f][2]}) begin
            n_bad++; $display("FAIL arith%0d_operands: got op %h a %h b %h, want %h %h %h",
               f, en_op, en_a, en_b, fr[f][0][3:0], fr[f][1], fr[f][2]);
         end
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (txb(base + i) !== ex[f][i] || txc_q[base + i] != c + 3 + i) begin
               n_bad++; $display("FAIL arith%0d_byte%0d: got %h at +%0d, want %h at +%0d",
                  f, i, txb(base + i), txc_q[base + i] - c, ex[f][i], 3 + i);
            end
         end
         n_cmp++;
         if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            n_bad++; $display("FAIL arith%0d_idle: got busy %b tx_valid %b, want 0 0", f, busy, tx_valid);
         end
      end
   endtask

   task automatic test_invalid();
      logic [7:0] codes [3];
      int base, e0, o0, c;
      codes = '{8'h0F, 8'h20, 8'h0E};
      for (int k = 0; k < 3; k++) begin
         base = tx_q.size(); e0 = en_cnt; o0 = eo_cnt;
         send_byte(codes[k]);
         c = rx_cyc;
         wait_tx(base + 1, "invalid");
         wait_cyc(c + 3);
         n_cmp++;
         if (txb(base) !== 8'hEE || txc_q[base] != c + 1) begin
            n_bad++; $display("FAIL invalid_%h_byte: got %h at +%0d, want EE at +1", codes[k], txb(base), txc_q[base] - c);
         end
         n_cmp++;
         if (eo_cnt - o0 != 1 || eo_cyc != c + 1) begin
            n_bad++; $display("FAIL invalid_%h_err: got %0d pulses at +%0d, want 1 at +1", codes[k], eo_cnt - o0, eo_cyc - c);
         end
         n_cmp++;
         if (en_cnt != e0 || tx_q.size() != base + 1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL invalid_%h_quiet: got alu_en %0d bytes %0d busy %b, want 0 1 0",
               codes[k], en_cnt - e0, tx_q.size() - base, busy);
         end
      end
   endtask

   task automatic test_timeout();
      int base, t0, c;
      t0 = to_cnt;
      send_byte(8'h01);
      c = rx_cyc;
      wait_cyc(c + 17);
      n_cmp++;
      if (err_timeout !== 1'b1 || busy !== 1'b0) begin
         n_bad++; $display("FAIL timeout_pulse: got err_timeout %b busy %b, want 1 0", err_timeout, busy);
      end
      base = tx_q.size();
      send_byte(8'h05); send_byte(8'h03); send_byte(8'h01);
      wait_tx(base + 3, "timeout");
      repeat (2) @(negedge clk);
      n_cmp++;
      if (to_cnt - t0 != 1 || to_cyc != c + 17) begin
         n_bad++; $display("FAIL timeout_count: got %0d pulses at +%0d, want 1 at +17", to_cnt - t0, to_cyc - c);
      end
      n_cmp++;
      if ({en_op, en_a, en_b} !== {4'h5, 8'h03, 8'h01}) begin
         n_bad++; $display("FAIL timeout_operands: got op %h a %h b %h, want 5 03 01", en_op, en_a, en_b);
      end
      n_cmp++;
      if ({txb(base), txb(base + 1), txb(base + 2)} !== 24'h030000) begin
         n_bad++; $display("FAIL timeout_bytes: got %h %h %h, want 03 00 00", txb(base), txb(base + 1), txb(base + 2));
      end
   endtask

   task automatic test_timeout_edge();
      int base, t0, c;
      t0 = to_cnt; base = tx_q.size();
      send_byte(8'h01);
      c = rx_cyc;
      wait_cyc(c + 16);
      send_byte(8'h03);
      send_byte(8'h01);
      wait_tx(base + 3, "edge");
      repeat (2) @(negedge clk);
      n_cmp++;
      if (to_cnt != t0) begin
         n_bad++; $display("FAIL edge_no_timeout: got %0d pulses, want 0", to_cnt - t0);
      end
      n_cmp++;
      if ({en_op, en_a, en_b, txb(base), txb(base + 1), txb(base + 2)} !== {4'h1, 8'h03, 8'h01, 24'h020000}) begin
         n_bad++; $display("FAIL edge_frame: got op %h a %h b %h bytes %h %h %h, want 1 03 01 02 00 00",
            en_op, en_a, en_b, txb(base), txb(base + 1), txb(base + 2));
      end
   endtask

   task automatic test_backpressure();
      int base, d0, c, bad;
      base = tx_q.size(); d0 = drop_cnt; bad = 0;
      tx_ready = 1'b1;
      send_byte(8'h02); send_byte(8'h10); send_byte(8'h10);
      c = rx_cyc;
      wait_cyc(c + 3);
      @(posedge clk); #1 tx_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 2) begin rx_data = 8'hAA; rx_valid = 1'b1; end
         if (i == 3) rx_valid = 1'b0;
         n_cmp++;
         if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
            n_bad++; $display("FAIL stall_hold_%0d: got tx_valid %b tx_data %h, want 1 01", i, tx_valid, tx_data);
         end
      end
      @(posedge clk); #1 tx_ready = 1'b1;
      wait_tx(base + 3, "stall");
      repeat (2) @(negedge clk);
      n_cmp++;
      if (drop_cnt - d0 != 1) begin
         n_bad++; $display("FAIL stall_rx_drop: got %0d pulses, want 1", drop_cnt - d0);
      end
      n_cmp++;
      if (tx_q.size() != base + 3 || {txb(base), txb(base + 1), txb(base + 2)} !== 24'h000104) begin
         n_bad++; $display("FAIL stall_bytes: got %0d bytes %h %h %h, want 3 00 01 04",
            tx_q.size() - base, txb(base), txb(base + 1), txb(base + 2));
      end
   endtask

   task automatic test_reset_mid();
      int base, c;
      base = tx_q.size();
      tx_ready = 1'b1;
      send_byte(8'h00); send_byte(8'h05); send_byte(8'h03);
      c = rx_cyc;
      wait_cyc(c + 3);
      @(posedge clk); #1 tx_ready = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({alu_a, alu_b, alu_op, alu_en, tx_data, tx_valid, busy, err_opcode, err_timeout, rx_drop} !== 34'h0) begin
         n_bad++; $display("FAIL midreset_outputs: got %h, want 0",
            {alu_a, alu_b, alu_op, alu_en, tx_data, tx_valid, busy, err_opcode, err_timeout, rx_drop});
      end
      @(negedge clk);
      rst = 1'b0; tx_ready = 1'b1;
      n_cmp++;
      if (tx_q.size() != base + 1) begin
         n_bad++; $display("FAIL midreset_dropped: got %0d bytes sent, want 1", tx_q.size() - base);
      end
      base = tx_q.size();
      send_byte(8'h00); send_byte(8'h01); send_byte(8'h01);
      wait_tx(base + 3, "midreset");
      n_cmp++;
      if ({txb(base), txb(base + 1), txb(base + 2)} !== 24'h020000) begin
         n_bad++; $display("FAIL midreset_frame: got %h %h %h, want 02 00 00", txb(base), txb(base + 1), txb(base + 2));
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_invalid();
      test_timeout();
      test_timeout_edge();
      test_backpressure();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
